ysyx_22050039_ifu: RTL

Instruction fetch unit directly upstream of the decode/regfile stage (IDU). Owns the architectural PC and fetches 32-bit instructions over a 64-bit valid/ready memory port. Presents one instruction at a time to the decoder. Takes the next PC from EXU redirect (pc_wen/dnpc) or pc+4. Holds a one-entry sequential prefetch buffer, so a not-taken flow costs no extra memory round-trip.

---
 rtl/ysyx_22050039_ifu_pkg.sv | 17 +
 rtl/ysyx_22050039_ifu_pfbuf.sv | 73 +++++++
 rtl/ysyx_22050039_ifu.sv | 111 +++++++++++
 3 files changed

// File: rtl/ysyx_22050039_ifu_pkg.sv
// Fetch-stage constants, FSM encodings and the 64-bit bus word-select helper.
// Shared by the IFU top and its prefetch buffer; no logic of its own.
package ysyx_22050039_ifu_pkg;

    localparam int          XLEN     = 64;
    localparam int          INST_LEN = 32;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {F_REQ, F_WAIT, F_VALID, F_DROP} fetch_st_t;
    typedef enum logic [1:0] {PF_IDLE, PF_REQ, PF_WAIT, PF_FULL} pf_st_t;

    // Bit 2 of the request address picks the 32-bit half of the 64-bit beat.
    function automatic logic [INST_LEN-1:0] word_sel(input logic hi, input logic [XLEN-1:0] dw);
        return hi ? dw[63:32] : dw[31:0];
    endfunction

endpackage

// File: rtl/ysyx_22050039_ifu_pfbuf.sv
// One-entry sequential prefetch of inst_pc+4 while an instruction waits in F_VALID.
// Issues one request per held instruction, then holds until consumed or discarded.
module ysyx_22050039_ifu_pfbuf
    import ysyx_22050039_ifu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                active,
    input  logic                consume,
    input  logic [XLEN-1:0]     inst_pc,
    input  logic [XLEN-1:0]     next_pc,
    input  logic                req_ready,
    input  logic                rsp_valid,
    input  logic [XLEN-1:0]     rsp_data,
    output logic                req_vld,
    output logic [XLEN-1:0]     req_pc,
    output logic                full,
    output logic                pend_req,
    output logic                pend_rsp,
    output logic                match,
    output logic [INST_LEN-1:0] word
);

    pf_st_t                st_q, st_d, eff_st;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic [INST_LEN-1:0]   word_q, word_d;

    // eff_st folds in this cycle's handshake/response so a same-cycle consume sees it.
    always_comb begin
        st_d   = st_q;
        pc_d   = pc_q;
        word_d = word_q;
        eff_st = st_q;
        case (st_q)
            PF_IDLE: if (active) begin
                st_d = PF_REQ;
                pc_d = inst_pc + 64'd4;
            end
            PF_REQ: if (req_ready) begin
                st_d   = PF_WAIT;
                eff_st = PF_WAIT;
            end
            PF_WAIT: if (rsp_valid) begin
                st_d   = PF_FULL;
                eff_st = PF_FULL;
                word_d = word_sel(pc_q[2], rsp_data);
            end
            default: ;
        endcase
        if (consume) st_d = PF_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= PF_IDLE;
            pc_q   <= '0;
            word_q <= '0;
        end else begin
            st_q   <= st_d;
            pc_q   <= pc_d;
            word_q <= word_d;
        end
    end

    assign req_vld  = (st_q == PF_REQ);
    assign req_pc   = pc_q;
    assign full     = (eff_st == PF_FULL);
    assign pend_req = (eff_st == PF_REQ);
    assign pend_rsp = (eff_st == PF_WAIT);
    assign match    = (pc_q == next_pc);
    assign word     = word_d;

endmodule

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch: owns the PC, 2-cycle min fetch, 0-bubble sequential issue from prefetch.
// IDU backpressure holds inst/inst_pc; one memory request outstanding, stale ones are drained.
module ysyx_22050039_ifu
    import ysyx_22050039_ifu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    output logic                req_valid,
    output logic [XLEN-1:0]     req_addr,
    input  logic                req_ready,
    input  logic                rsp_valid,
    input  logic [XLEN-1:0]     rsp_data,
    output logic [INST_LEN-1:0] inst,
    output logic [XLEN-1:0]     inst_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    input  logic                pc_wen,
    input  logic [XLEN-1:0]     dnpc
);

    fetch_st_t             fsm_q, fsm_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic [INST_LEN-1:0]   inst_q, inst_d;
    logic                  drop_q, drop_d;
    logic                  consume;
    logic [XLEN-1:0]       next_pc, req_base;
    logic                  pf_req_vld, pf_full, pf_pend_req, pf_pend_rsp, pf_match;
    logic [XLEN-1:0]       pf_pc;
    logic [INST_LEN-1:0]   pf_word;

    assign consume = (fsm_q == F_VALID) & inst_ready;
    assign next_pc = pc_wen ? (dnpc & ~64'd3) : pc_q + 64'd4;

    ysyx_22050039_ifu_pfbuf u_pfbuf (
        .clk       (clk),
        .rst       (rst),
        .active    (fsm_q == F_VALID),
        .consume   (consume),
        .inst_pc   (pc_q),
        .next_pc   (next_pc),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .req_vld   (pf_req_vld),
        .req_pc    (pf_pc),
        .full      (pf_full),
        .pend_req  (pf_pend_req),
        .pend_rsp  (pf_pend_rsp),
        .match     (pf_match),
        .word      (pf_word)
    );

    // pf_match is only meaningful when a prefetch exists: its pc is inst_pc+4 then.
    always_comb begin
        fsm_d  = fsm_q;
        pc_d   = pc_q;
        inst_d = inst_q;
        drop_d = drop_q;
        case (fsm_q)
            F_REQ: if (req_ready) fsm_d = F_WAIT;
            F_WAIT: if (rsp_valid) begin
                inst_d = word_sel(pc_q[2], rsp_data);
                fsm_d  = F_VALID;
            end
            F_VALID: if (consume) begin
                pc_d = next_pc;
                if (pf_full && pf_match) begin
                    inst_d = pf_word;
                end else if (pf_pend_rsp && pf_match) begin
                    fsm_d = F_WAIT;
                end else if (pf_pend_req || pf_pend_rsp) begin
                    fsm_d  = pf_match ? F_REQ : F_DROP;
                    drop_d = pf_pend_req && !pf_match;
                end else begin
                    fsm_d = F_REQ;
                end
            end
            F_DROP: begin
                if (drop_q) begin
                    if (req_ready) drop_d = 1'b0;
                end else if (rsp_valid) begin
                    fsm_d = F_REQ;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= F_REQ;
            pc_q   <= RESET_PC;
            inst_q <= '0;
            drop_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            pc_q   <= pc_d;
            inst_q <= inst_d;
            drop_q <= drop_d;
        end
    end

    // A stale prefetch still awaiting acceptance keeps driving its own address from F_DROP.
    assign req_base   = (fsm_q == F_REQ) ? pc_q : pf_pc;
    assign req_addr   = req_base & ~64'd7;
    assign req_valid  = ~rst & ((fsm_q == F_REQ) | pf_req_vld | ((fsm_q == F_DROP) & drop_q));
    assign inst_valid = (fsm_q == F_VALID);
    assign inst       = inst_q;
    assign inst_pc    = pc_q;

endmodule
